mmio_io_port: RTL and testbench

Memory-mapped I/O responder on the processor's data-memory bus, sitting beside `dmem` at the other end of the load/store interface. It answers processor stores and loads inside a 32-byte address window. It also exposes:
- an LED output register;
- synchronized switch inputs with sticky change flags;
- a 32-bit down-counting timer with auto-reload.

The top level muxes its `rd` against `dmem`'s read data using `sel`.

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/mmio_io_port_sw_sync.sv | 37 +++
 rtl/mmio_io_port.sv | 171 +++++++++++++++++
 tb/tb_mmio_io_port.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped I/O port.
//   - byte offsets of every register inside the 32-byte window
//   - word indices derived from those offsets (a[4:2])
//   - TCTRL bit positions
//   - 3-bit register-index type
package mmio_pkg;

    typedef logic [2:0] reg_idx_t;

    localparam logic [4:0] LEDR_OFS   = 5'h00;
    localparam logic [4:0] SWR_OFS    = 5'h04;
    localparam logic [4:0] SWCHG_OFS  = 5'h08;
    localparam logic [4:0] TLOAD_OFS  = 5'h0C;
    localparam logic [4:0] TCOUNT_OFS = 5'h10;
    localparam logic [4:0] TCTRL_OFS  = 5'h14;
    localparam logic [4:0] TSTAT_OFS  = 5'h18;

    // Word index of each register, as seen on a[4:2]
    localparam reg_idx_t LEDR_IDX   = LEDR_OFS[4:2];
    localparam reg_idx_t SWR_IDX    = SWR_OFS[4:2];
    localparam reg_idx_t SWCHG_IDX  = SWCHG_OFS[4:2];
    localparam reg_idx_t TLOAD_IDX  = TLOAD_OFS[4:2];
    localparam reg_idx_t TCOUNT_IDX = TCOUNT_OFS[4:2];
    localparam reg_idx_t TCTRL_IDX  = TCTRL_OFS[4:2];
    localparam reg_idx_t TSTAT_IDX  = TSTAT_OFS[4:2];

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;

endpackage

// File: rtl/mmio_io_port_sw_sync.sv
// sw_sync: brings asynchronous switch inputs into the clk domain.
//   clk, reset : clock and asynchronous active-high reset
//   d          : raw switch inputs
//   q          : synchronized switch value (second synchronizer flop)
//   chg        : per-bit pulse, high for one cycle after q changes
module sw_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] chg
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;
    logic [W-1:0] prev_r;

    // Two-flop synchronizer followed by the previous-value register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= '0;
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign q   = sync_r;
    // Both operands are flops, so the pulse is glitch-free and lasts one cycle
    assign chg = sync_r ^ prev_r;

endmodule

// File: rtl/mmio_io_port.sv
// mmio_io_port: memory-mapped I/O responder beside dmem.
//   clk, reset : processor clock, asynchronous active-high reset
//   we, a, wd  : store strobe, byte address and store data from the memory stage
//   rd, sel    : combinational load data and window hit (top muxes rd over dmem)
//   SW         : raw asynchronous switch inputs
//   LED        : LED register contents
// Holds the LED register, switch value/change flags and a 32-bit
// down-counting timer with optional auto-reload.
module mmio_io_port
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          LED_W     = 10,
    parameter int          SW_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [31:0]      a,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic             sel,
    input  logic [SW_W-1:0]  SW,
    output logic [LED_W-1:0] LED
);

    logic             sel_s;
    reg_idx_t         idx_s;
    logic             unused_s;
    logic [SW_W-1:0]  sw_val_s;
    logic [SW_W-1:0]  sw_chg_s;

    logic             wr_ledr_s, wr_swchg_s, wr_tload_s, wr_tctrl_s, wr_tstat_s;

    logic [LED_W-1:0] led_r, led_n_s;
    logic [SW_W-1:0]  swchg_r, swchg_n_s;
    logic [31:0]      tload_r, tload_n_s;
    logic [31:0]      tcount_r, tcount_n_s;
    logic             en_r, en_n_s;
    logic             auto_r, auto_n_s;
    logic             exp_r, exp_n_s;
    logic             exp_set_s, en_clr_s;
    logic [31:0]      rd_s;

    assign sel_s    = (a[31:5] == BASE_ADDR[31:5]);
    assign idx_s    = a[4:2];
    // Byte lanes within a word are not distinguished
    assign unused_s = ^a[1:0];

    assign wr_ledr_s  = we && sel_s && (idx_s == LEDR_IDX);
    assign wr_swchg_s = we && sel_s && (idx_s == SWCHG_IDX);
    assign wr_tload_s = we && sel_s && (idx_s == TLOAD_IDX);
    assign wr_tctrl_s = we && sel_s && (idx_s == TCTRL_IDX);
    assign wr_tstat_s = we && sel_s && (idx_s == TSTAT_IDX);

    sw_sync #(.W(SW_W)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (SW),
        .q     (sw_val_s),
        .chg   (sw_chg_s)
    );

    // Next-state logic for the register file and timer
    always_comb begin
        led_n_s    = led_r;
        swchg_n_s  = swchg_r;
        tload_n_s  = tload_r;
        tcount_n_s = tcount_r;
        en_n_s     = en_r;
        auto_n_s   = auto_r;
        exp_n_s    = exp_r;
        exp_set_s  = 1'b0;
        en_clr_s   = 1'b0;

        if (wr_ledr_s) begin
            led_n_s = wd[LED_W-1:0];
        end else begin
            led_n_s = led_r;
        end

        // Hardware set is OR-ed in after the clear so it wins a collision
        if (wr_swchg_s) begin
            swchg_n_s = (swchg_r & ~wd[SW_W-1:0]) | sw_chg_s;
        end else begin
            swchg_n_s = swchg_r | sw_chg_s;
        end

        if (wr_tload_s) begin
            tload_n_s = wd;
        end else begin
            tload_n_s = tload_r;
        end

        // A TLOAD write overrides decrement, reload and the EN auto-clear
        if (wr_tload_s) begin
            tcount_n_s = wd;
        end else if (en_r && (tcount_r != 32'd0)) begin
            tcount_n_s = tcount_r - 32'd1;
            exp_set_s  = (tcount_r == 32'd1);
        end else if (en_r && auto_r) begin
            tcount_n_s = tload_r;
        end else if (en_r) begin
            en_clr_s   = 1'b1;
        end else begin
            tcount_n_s = tcount_r;
        end

        if (wr_tctrl_s) begin
            en_n_s   = wd[TCTRL_EN];
            auto_n_s = wd[TCTRL_AUTO];
        end else if (en_clr_s) begin
            en_n_s   = 1'b0;
        end else begin
            en_n_s   = en_r;
        end

        if (exp_set_s) begin
            exp_n_s = 1'b1;
        end else if (wr_tstat_s && wd[0]) begin
            exp_n_s = 1'b0;
        end else begin
            exp_n_s = exp_r;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r    <= '0;
            swchg_r  <= '0;
            tload_r  <= 32'd0;
            tcount_r <= 32'd0;
            en_r     <= 1'b0;
            auto_r   <= 1'b0;
            exp_r    <= 1'b0;
        end else begin
            led_r    <= led_n_s;
            swchg_r  <= swchg_n_s;
            tload_r  <= tload_n_s;
            tcount_r <= tcount_n_s;
            en_r     <= en_n_s;
            auto_r   <= auto_n_s;
            exp_r    <= exp_n_s;
        end
    end

    // Combinational load-data mux; zero outside the window and at reserved offsets
    always_comb begin
        rd_s = 32'd0;
        if (sel_s) begin
            case (idx_s)
                LEDR_IDX:   rd_s = {{(32-LED_W){1'b0}}, led_r};
                SWR_IDX:    rd_s = {{(32-SW_W){1'b0}}, sw_val_s};
                SWCHG_IDX:  rd_s = {{(32-SW_W){1'b0}}, swchg_r};
                TLOAD_IDX:  rd_s = tload_r;
                TCOUNT_IDX: rd_s = tcount_r;
                TCTRL_IDX:  rd_s = {30'd0, auto_r, en_r};
                TSTAT_IDX:  rd_s = {31'd0, exp_r};
                default:    rd_s = 32'd0;
            endcase
        end else begin
            rd_s = 32'd0;
        end
    end

    assign rd  = rd_s;
    assign sel = sel_s;
    assign LED = led_r;

endmodule

// File: tb/tb_mmio_io_port.sv
// Self-checking bench for mmio_io_port: a behavioural model tracks the
// register map from the documented rules, a compare process checks rd/sel/LED
// against it every falling edge, and directed reads pin known values.
module tb_mmio_io_port;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;
    logic [3:0]  SW;
    logic [9:0]  LED;

    int n_chk  = 0;
    int n_fail = 0;

    mmio_io_port #(.BASE_ADDR(32'h0000_0400), .LED_W(10), .SW_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .sel   (sel),
        .SW    (SW),
        .LED   (LED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // h0/h1/h2: SW as sampled at the last three rising edges (h0 newest)
    logic [9:0]  m_led;
    logic [3:0]  h0, h1, h2, m_swchg;
    logic [31:0] m_tload, m_tcount;
    logic        m_en, m_auto, m_exp;

    wire       m_hit = (a[31:5] == BASE[31:5]);
    wire       m_wr  = we && m_hit;
    wire [2:0] m_ix  = a[4:2];
    wire       m_ldw = m_wr && (m_ix == 3'd3);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_led <= 10'd0; h0 <= 4'd0; h1 <= 4'd0; h2 <= 4'd0; m_swchg <= 4'd0;
            m_tload <= 32'd0; m_tcount <= 32'd0;
            m_en <= 1'b0; m_auto <= 1'b0; m_exp <= 1'b0;
        end else begin
            h0 <= SW; h1 <= h0; h2 <= h1;
            if (m_wr && m_ix == 3'd0) m_led <= wd[9:0];
            m_swchg <= ((m_wr && m_ix == 3'd2) ? (m_swchg & ~wd[3:0]) : m_swchg) | (h1 ^ h2);
            if (m_ldw) m_tload <= wd;
            if (m_ldw)                          m_tcount <= wd;
            else if (m_en && m_tcount != 32'd0) m_tcount <= m_tcount - 32'd1;
            else if (m_en && m_auto)            m_tcount <= m_tload;
            if (m_wr && m_ix == 3'd5) begin
                m_en <= wd[0]; m_auto <= wd[1];
            end else if (!m_ldw && m_en && !m_auto && m_tcount == 32'd0) begin
                m_en <= 1'b0;
            end
            if (!m_ldw && m_en && m_tcount == 32'd1) m_exp <= 1'b1;
            else if (m_wr && m_ix == 3'd6 && wd[0])  m_exp <= 1'b0;
        end
    end

    function automatic logic [31:0] mread(input logic [31:0] addr);
        if (addr[31:5] != BASE[31:5]) return 32'd0;
        case (addr[4:2])
            3'd0:    return {22'd0, m_led};
            3'd1:    return {28'd0, h1};
            3'd2:    return {28'd0, m_swchg};
            3'd3:    return m_tload;
            3'd4:    return m_tcount;
            3'd5:    return {30'd0, m_auto, m_en};
            3'd6:    return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, outputs against the model
    always @(negedge clk) begin
        chk("cmp_sel", {31'd0, sel}, {31'd0, (a[31:5] == BASE[31:5])});
        chk("cmp_rd", rd, mread(a));
        chk("cmp_led", {22'd0, LED}, {22'd0, m_led});
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        a = addr; wd = data; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic load_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        a = addr;
        #1;
        chk(name, rd, exp);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; a = 32'd0; wd = 32'd0; SW = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 8; i++) begin
            load_chk("reset_read", 32'h400 + 32'(i * 4), 32'd0);
            if (i % 2 == 1) step();
        end
        chk("reset_led", {22'd0, LED}, 32'd0);
        a = 32'h3FC; #1; chk("sel_below", {31'd0, sel}, 32'd0);
        a = 32'h420; #1; chk("sel_above", {31'd0, sel}, 32'd0);
        step();
        a = 32'h41F; #1; chk("sel_top", {31'd0, sel}, 32'd1);

        // LED stores and ignored writes
        store(32'h400, 32'h3FF);
        chk("led_3ff", {22'd0, LED}, 32'h3FF);
        load_chk("ledr_3ff", 32'h400, 32'h3FF);
        store(32'h400, 32'hFFFF_F000);
        chk("led_trunc", {22'd0, LED}, 32'd0);
        load_chk("ledr_trunc", 32'h400, 32'd0);
        store(32'h420, 32'h155);
        chk("led_outside", {22'd0, LED}, 32'd0);
        store(32'h41C, 32'hFFFF_FFFF);
        load_chk("rsvd_read", 32'h41C, 32'd0);
        store(32'h404, 32'hF);
        load_chk("swr_ro", 32'h404, 32'd0);

        // Switch change latency
        SW = 4'b0101;
        load_chk("swr_pre", 32'h404, 32'd0);
        step();
        load_chk("swr_n", 32'h404, 32'd0);
        step();
        load_chk("swr_n1", 32'h404, 32'd5);
        load_chk("swchg_n1", 32'h408, 32'd0);
        step();
        load_chk("swchg_n2", 32'h408, 32'd5);

        // W1C colliding with a new change on bit 1
        SW = 4'b0111;
        step();
        step();
        store(32'h408, 32'd5);
        load_chk("swchg_coll", 32'h408, 32'd2);
        load_chk("swr_7", 32'h404, 32'd7);
        store(32'h408, 32'd2);
        load_chk("swchg_clr", 32'h408, 32'd0);

        // One-shot timer
        store(32'h40C, 32'd3);
        load_chk("os_load", 32'h410, 32'd3);
        store(32'h414, 32'd1);
        load_chk("os_c3", 32'h410, 32'd3);
        load_chk("os_en", 32'h414, 32'd1);
        step(); load_chk("os_c2", 32'h410, 32'd2);
        step(); load_chk("os_c1", 32'h410, 32'd1);
        step();
        load_chk("os_c0", 32'h410, 32'd0);
        load_chk("os_exp", 32'h418, 32'd1);
        load_chk("os_en_still", 32'h414, 32'd1);
        step();
        load_chk("os_en_clr", 32'h414, 32'd0);
        load_chk("os_hold0", 32'h410, 32'd0);
        store(32'h418, 32'd1);
        load_chk("os_exp_clr", 32'h418, 32'd0);

        // TCTRL write on the auto-clear edge wins
        store(32'h414, 32'd1);
        store(32'h414, 32'd1);
        load_chk("ctl_wins", 32'h414, 32'd1);
        step();
        load_chk("ctl_clr", 32'h414, 32'd0);
        load_chk("ctl_cnt0", 32'h410, 32'd0);

        // Auto-reload
        store(32'h40C, 32'd2);
        store(32'h414, 32'd3);
        load_chk("ar_c2", 32'h410, 32'd2);
        step(); load_chk("ar_c1", 32'h410, 32'd1);
        step();
        load_chk("ar_c0", 32'h410, 32'd0);
        load_chk("ar_exp", 32'h418, 32'd1);
        store(32'h418, 32'd1);
        load_chk("ar_reload", 32'h410, 32'd2);
        load_chk("ar_exp_clr", 32'h418, 32'd0);
        step(); load_chk("ar_c1b", 32'h410, 32'd1);
        store(32'h418, 32'd1);
        load_chk("ar_c0b", 32'h410, 32'd0);
        load_chk("ar_set_wins", 32'h418, 32'd1);
        step(); load_chk("ar_c2b", 32'h410, 32'd2);
        step(); step();
        load_chk("ar_c0c", 32'h410, 32'd0);
        store(32'h40C, 32'd7);
        load_chk("ar_ld_wins", 32'h410, 32'd7);
        load_chk("ar_tload7", 32'h40C, 32'd7);
        step(); step();
        load_chk("rst_pre_c5", 32'h410, 32'd5);

        // Asynchronous reset mid-count
        reset = 1'b1;
        load_chk("rst_cnt", 32'h410, 32'd0);
        load_chk("rst_ctl", 32'h414, 32'd0);
        load_chk("rst_exp", 32'h418, 32'd0);
        load_chk("rst_tload", 32'h40C, 32'd0);
        reset = 1'b0;
        step();
        load_chk("rel_cnt", 32'h410, 32'd0);
        load_chk("rel_ctl", 32'h414, 32'd0);
        step();
        load_chk("rel_cnt2", 32'h410, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
